inputs_gather: RTL and testbench



---
 rtl/inputs_gather_if.sv | 23 ++
 rtl/inputs_gather.sv | 77 +++++++
 tb/tb_inputs_gather.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inputs_gather_if.sv
// rtl/inputs_gather_if.sv - per-lane input handshakes and gathered output beat of inputs_gather
interface inputs_gather_if #(
  parameter int width_p  = 16,
  parameter int num_in_p = 4
);
  logic [num_in_p-1:0]               v_i;
  logic [num_in_p-1:0][width_p-1:0]  data_i;
  logic [num_in_p-1:0]               ready_o;
  logic                              v_o;
  logic [num_in_p-1:0][width_p-1:0]  data_o;
  logic                              yumi_i;
  logic [31:0]                       count_o;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, count_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, count_o
  );
endinterface

// File: rtl/inputs_gather.sv
// rtl/inputs_gather.sv - gathers independent lanes, each with a 2-entry buffer, into one wide beat
module inputs_gather #(
  parameter int width_p  = 16,
  parameter int num_in_p = 4
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  inputs_gather_if.slave  bus
);

  logic [width_p-1:0]   mem   [num_in_p][2];
  logic [1:0]           occ_r [num_in_p];
  logic [num_in_p-1:0]  head_r;
  logic [num_in_p-1:0]  tail_r;
  logic                 rdy_en_r;
  logic [31:0]          count_r;

  logic [num_in_p-1:0]  nonempty;
  logic [num_in_p-1:0]  rdy;
  logic [num_in_p-1:0]  enq;
  logic                 deq;

  // rdy_en_r keeps ready_o low throughout reset and sets on the first edge after release
  always_comb begin
    nonempty = '0;
    rdy      = '0;
    for (int k = 0; k < num_in_p; k++) begin
      nonempty[k] = (occ_r[k] != 2'd0);
    end
    deq = bus.yumi_i & (&nonempty);
    for (int k = 0; k < num_in_p; k++) begin
      rdy[k] = rdy_en_r & ((occ_r[k] != 2'd2) | deq);
    end
    enq = bus.v_i & rdy;
  end

  assign bus.v_o     = &nonempty;
  assign bus.ready_o = rdy;
  assign bus.count_o = count_r;

  generate
    for (genvar g = 0; g < num_in_p; g++) begin : g_lane_out
      assign bus.data_o[g] = mem[g][head_r[g]];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdy_en_r <= 1'b0;
      count_r  <= 32'd0;
      head_r   <= '0;
      tail_r   <= '0;
      for (int k = 0; k < num_in_p; k++) begin
        occ_r[k]  <= 2'd0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
    end else begin
      rdy_en_r <= 1'b1;
      if (deq) begin
        count_r <= count_r + 32'd1;
      end
      for (int k = 0; k < num_in_p; k++) begin
        if (enq[k]) begin
          mem[k][tail_r[k]] <= bus.data_i[k];
          tail_r[k]         <= ~tail_r[k];
        end
        // with occ=1 the tail slot is the other slot, so enq+deq lands head on the new word
        if (deq) begin
          head_r[k] <= ~head_r[k];
        end
        occ_r[k] <= occ_r[k] + {1'b0, enq[k]} - {1'b0, deq};
      end
    end
  end

endmodule

// File: tb/tb_inputs_gather.sv
// tb/tb_inputs_gather.sv - scoreboard bench for inputs_gather with directed vectors
module tb_inputs_gather;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inputs_gather_if #(.width_p(16), .num_in_p(4)) bus ();

  inputs_gather #(.width_p(16), .num_in_p(4)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat(input logic [15:0] d3, input logic [15:0] d2,
                                       input logic [15:0] d1, input logic [15:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume(input logic [63:0] exp);
    chk("v_o_before_yumi", {63'd0, bus.v_o}, 64'd1);
    sb.push_back(exp);
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("count_after_beat", {32'd0, bus.count_o}, {32'd0, exp_cnt});
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.v_o && bus.yumi_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_beat: got %h want none at %0t", bus.data_o, $time);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if (bus.data_o !== e) begin
          bad++;
          $display("FAIL sb_beat: got %h want %h at %0t", bus.data_o, e, $time);
        end
      end
    end else if (rst_n && bus.yumi_i && !bus.v_o) begin
      $display("protocol error: yumi_i without v_o at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.v_i    = '0;
    bus.data_i = '0;
    bus.yumi_i = 1'b0;

    // reset held with random valid traffic
    for (int i = 0; i < 5; i++) begin
      bus.v_i = 4'($urandom_range(0, 15));
      bus.data_i = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      @(negedge clk);
      chk("rst_ready", {60'd0, bus.ready_o}, 64'd0);
      chk("rst_v_o", {63'd0, bus.v_o}, 64'd0);
      chk("rst_data", bus.data_o, 64'd0);
      chk("rst_count", {32'd0, bus.count_o}, 64'd0);
    end
    bus.v_i = '0;
    bus.data_i = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {60'd0, bus.ready_o}, 64'hF);

    // skewed arrival, one lane per cycle
    for (int i = 0; i < 4; i++) begin
      bus.v_i = 4'(1 << i);
      bus.data_i[i] = 16'h1000 + 16'(i) * 16'h1001;
      @(negedge clk);
      chk("skew_v_o_low", {63'd0, bus.v_o}, 64'd0);
      tick();
    end
    bus.v_i = '0;
    @(negedge clk);
    chk("skew_v_o_high", {63'd0, bus.v_o}, 64'd1);
    chk("skew_data", bus.data_o, beat(16'h4003, 16'h3002, 16'h2001, 16'h1000));
    tick();
    consume(beat(16'h4003, 16'h3002, 16'h2001, 16'h1000));
    chk("skew_drained", {63'd0, bus.v_o}, 64'd0);

    // back-pressure on lane 0, then enqueue on full during a dequeue
    bus.v_i = 4'b0001;
    bus.data_i[0] = 16'h00A0;
    @(negedge clk);
    chk("bp_ready0_a0", {63'd0, bus.ready_o[0]}, 64'd1);
    tick();
    bus.data_i[0] = 16'h00A1;
    @(negedge clk);
    chk("bp_ready0_a1", {63'd0, bus.ready_o[0]}, 64'd1);
    tick();
    bus.data_i[0] = 16'h00A2;
    @(negedge clk);
    chk("bp_ready0_full", {63'd0, bus.ready_o[0]}, 64'd0);
    tick();
    @(negedge clk);
    chk("bp_ready0_held", {63'd0, bus.ready_o[0]}, 64'd0);
    chk("bp_v_o_partial", {63'd0, bus.v_o}, 64'd0);
    tick();
    bus.v_i = 4'b1111;
    bus.data_i[1] = 16'h00B1;
    bus.data_i[2] = 16'h00C1;
    bus.data_i[3] = 16'h00D1;
    tick();
    bus.v_i = 4'b0001;
    sb.push_back(beat(16'h00D1, 16'h00C1, 16'h00B1, 16'h00A0));
    bus.yumi_i = 1'b1;
    @(negedge clk);
    chk("bp_ready0_enq_on_full", {63'd0, bus.ready_o[0]}, 64'd1);
    tick();
    bus.yumi_i = 1'b0;
    bus.v_i = '0;
    exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    chk("bp_occ0_stays2", {62'd0, dut.occ_r[0]}, 64'd2);
    chk("bp_ready0_after", {63'd0, bus.ready_o[0]}, 64'd0);
    chk("bp_count", {32'd0, bus.count_o}, {32'd0, exp_cnt});
    tick();
    bus.v_i = 4'b1110;
    bus.data_i[1] = 16'h00B2;
    bus.data_i[2] = 16'h00C2;
    bus.data_i[3] = 16'h00D2;
    tick();
    bus.v_i = '0;
    consume(beat(16'h00D2, 16'h00C2, 16'h00B2, 16'h00A1));
    bus.v_i = 4'b1110;
    bus.data_i[1] = 16'h00B3;
    bus.data_i[2] = 16'h00C3;
    bus.data_i[3] = 16'h00D3;
    tick();
    bus.v_i = '0;
    consume(beat(16'h00D3, 16'h00C3, 16'h00B3, 16'h00A2));
    chk("bp_drained", {63'd0, bus.v_o}, 64'd0);

    // streaming: yumi follows v_o, one beat per cycle after the first
    for (int n = 0; n < 100; n++) begin
      bus.v_i = 4'b1111;
      for (int k = 0; k < 4; k++) bus.data_i[k] = 16'((k << 12) | n);
      sb.push_back(beat(16'h3000 | 16'(n), 16'h2000 | 16'(n), 16'h1000 | 16'(n), 16'(n)));
      bus.yumi_i = bus.v_o;
      if (n > 0) chk("stream_v_o", {63'd0, bus.v_o}, 64'd1);
      tick();
    end
    bus.v_i = '0;
    bus.yumi_i = 1'b0;
    chk("stream_count_99", {32'd0, bus.count_o}, {32'd0, exp_cnt + 32'd99});
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    exp_cnt = exp_cnt + 32'd100;
    chk("stream_count_100", {32'd0, bus.count_o}, {32'd0, exp_cnt});
    chk("stream_drained", {63'd0, bus.v_o}, 64'd0);

    // illegal yumi while empty
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    @(negedge clk);
    chk("illegal_count", {32'd0, bus.count_o}, {32'd0, exp_cnt});
    chk("illegal_v_o", {63'd0, bus.v_o}, 64'd0);
    chk("illegal_ready", {60'd0, bus.ready_o}, 64'hF);
    tick();

    // count wrap
    @(negedge clk);
    force dut.count_r = 32'hFFFF_FFFF;
    #1;
    release dut.count_r;
    exp_cnt = 32'hFFFF_FFFF;
    chk("wrap_preload", {32'd0, bus.count_o}, 64'hFFFF_FFFF);
    tick();
    bus.v_i = 4'b1111;
    bus.data_i = beat(16'h00E3, 16'h00E2, 16'h00E1, 16'h00E0);
    tick();
    bus.v_i = '0;
    consume(beat(16'h00E3, 16'h00E2, 16'h00E1, 16'h00E0));
    chk("wrap_zero", {32'd0, bus.count_o}, 64'd0);

    // async reset with every lane full
    bus.v_i = 4'b1111;
    bus.data_i = beat(16'hF003, 16'hF002, 16'hF001, 16'hF000);
    tick();
    bus.data_i = beat(16'hF103, 16'hF102, 16'hF101, 16'hF100);
    tick();
    bus.v_i = '0;
    @(negedge clk);
    chk("full_ready", {60'd0, bus.ready_o}, 64'd0);
    chk("full_v_o", {63'd0, bus.v_o}, 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_v_o", {63'd0, bus.v_o}, 64'd0);
    chk("arst_count", {32'd0, bus.count_o}, 64'd0);
    chk("arst_data", bus.data_o, 64'd0);
    chk("arst_ready", {60'd0, bus.ready_o}, 64'd0);
    exp_cnt = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_ready_back", {60'd0, bus.ready_o}, 64'hF);
    chk("arst_v_o_after", {63'd0, bus.v_o}, 64'd0);
    bus.v_i = 4'b1111;
    bus.data_i = beat(16'h5553, 16'h5552, 16'h5551, 16'h5550);
    tick();
    bus.v_i = '0;
    consume(beat(16'h5553, 16'h5552, 16'h5551, 16'h5550));

    repeat (2) tick();
    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
